// File: rtl/rx_word_buffer_if.sv
// Byte-in / word-out bundle for rx_word_buffer.
// The master drives bytes and the pop handshake. The slave is the buffer itself.
interface rx_word_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    rdata;
  logic          rvalid;
  logic          flush;
  logic [31:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [CW-1:0] count;
  logic [1:0]    byte_phase;
  logic          overflow;

  modport master (
    output rdata, rvalid, flush, dout_ready,
    input  dout, dout_valid, count, byte_phase, overflow
  );

  modport slave (
    input  rdata, rvalid, flush, dout_ready,
    output dout, dout_valid, count, byte_phase, overflow
  );
endinterface

// File: rtl/rx_word_buffer.sv
// Packs UART bytes little-endian into 32-bit words.
// The words go into a first-word-fall-through FIFO with a sticky overflow flag.
module rx_word_buffer #(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  rx_word_buffer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    phase_q, phase_d;
  logic [23:0]   partial_q, partial_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [31:0]   mem [DEPTH];

  logic          not_empty;
  logic          full;
  logic          push_req;
  logic          pop;
  logic          push;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign push_req  = bus.rvalid && (phase_q == 2'd3) && !bus.flush;
  assign pop       = not_empty && bus.dout_ready && !bus.flush;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);

  assign bus.dout       = mem[rd_ptr_q];
  assign bus.dout_valid = not_empty;
  assign bus.count      = count_q;
  assign bus.byte_phase = phase_q;
  assign bus.overflow   = overflow_q;

  always_comb begin
    phase_d    = phase_q;
    partial_d  = partial_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (bus.flush) begin
      phase_d    = '0;
      partial_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (bus.rvalid) begin
        phase_d = phase_q + 2'd1;
        case (phase_q)
          2'd0:    partial_d[7:0]   = bus.rdata;
          2'd1:    partial_d[15:8]  = bus.rdata;
          2'd2:    partial_d[23:16] = bus.rdata;
          default: partial_d        = '0;
        endcase
      end

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      if (push_req && !push) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      partial_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      partial_q  <= partial_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {bus.rdata, partial_q};
  end
endmodule
